controlador_sequenciador: RTL and testbench
===========================================

# controlador_sequenciador

SAP-1 controller-sequencer: a six-state ring counter (T1–T6) that decodes the instruction-register opcode and drives the control word for the whole datapath. It sits directly upstream of the program counter and generates its Cp, Ep and Ej inputs. It also generates the MAR, RAM, IR, accumulator, B, ALU and output-register controls. States advance on the falling edge of CLK, so the control word is stable before every rising edge, where the datapath acts on it.

## Interface
- No parameters.
- CLK  in  1  system clock; ring advances on negedge.
- CLR  in  1  reset, asynchronous, active-high; clock CLK.
- Opcode  in  4  IR upper nibble.
- Zf  in  1  accumulator-zero flag, used by JZ.
- Cp  out  1  PC increment.
- Ep  out  1  PC output enable.
- Ej  out  1  PC jump load.
- Lm_n  out  1  MAR load, active-low.
- CE_n  out  1  RAM output enable, active-low.
- Li_n  out  1  IR load, active-low.
- Ei_n  out  1  IR address-nibble enable, active-low.
- La_n  out  1  accumulator load, active-low.
- Ea  out  1  accumulator output enable.
- Su  out  1  ALU subtract select.
- Eu  out  1  ALU output enable.
- Lb_n  out  1  B register load, active-low.
- Lo_n  out  1  output register load, active-low.
- T  out  6  one-hot ring state; T[0]=T1 … T[5]=T6.
- HLT  out  1  halted flag.

## Operation
- State register:
  - one-hot ring T1→T2→…→T6→T1, updated on negedge CLK;
  - CLR forces T=6'b000001 and HLT=0 immediately, regardless of CLK.
- Control word is decoded combinationally from T, Opcode and Zf.
- Any signal not listed for a state is inactive (active-high=0, active-low=1).
- Fetch, identical for every opcode:
  - T1: Ep=1, Lm_n=0.
  - T2: Cp=1.
  - T3: CE_n=0, Li_n=0.
- Execute by opcode (T4 / T5 / T6):
  - LDA 0000: Ei_n=0, Lm_n=0 / CE_n=0, La_n=0 / none.
  - ADD 0001: Ei_n=0, Lm_n=0 / CE_n=0, Lb_n=0 / Eu=1, La_n=0.
  - SUB 0010: same as ADD; Su=1 in T6 only.
  - JMP 0011: Ei_n=0, Ej=1 / none / none.
  - JZ 0100: if Zf=1 in T4, same as JMP; else none in all three states.
  - OUT 1110: Ea=1, Lo_n=0 / none / none.
  - HLT 1111: none in T4; see halt rule.
  - All other opcodes: NOP, no controls in T4–T6.
- Halt rule:
  - At the negedge ending a T4 with Opcode=1111, HLT is set to 1 and the ring stays at T4.
  - While HLT=1, the ring is frozen and the control word is all inactive.
  - Only CLR clears HLT.
- Ej is never asserted together with Cp; the jump and the increment fall in different T states.
- Exactly one bit of T is high at all times.
- Illegal one-hot values (not reachable) recover to T1 on the next negedge.

## Timing
- One instruction takes 6 CLK cycles; a halted instruction stops in T4.
- Reset values:
  - T=000001, HLT=0.
  - Control word as in T1: Ep=1, Lm_n=0; all other outputs inactive.
- Control outputs change only after a negedge or on CLR assertion, never near posedge.
- Opcode is read during T4–T6 only; its value in T1–T3 has no effect.
- IR loads at the posedge inside T3, so Opcode is valid from T4.
- Zf is read combinationally during T4 only.
- Jump latency: PC holds the target after the posedge inside T4; the next fetch (T1) presents it.
- CLR mid-instruction, in any state or while halted:
  - immediate return to T1 with HLT=0;
  - the instruction in progress is abandoned, with no partial controls after CLR asserts.
- CLR released between edges: the first negedge after release moves T1→T2.

## Test plan
- Reset and free run: assert CLR with Opcode=0000; T=000001, Ep=1, Lm_n=0. Release CLR; T sequences 000010, 000100, …, 100000, 000001 over six negedges.
- LDA and ADD decode:
  - Opcode=0000: T4 gives Ei_n=0, Lm_n=0; T5 gives CE_n=0, La_n=0; T6 is all inactive.
  - Opcode=0001: T5 gives Lb_n=0; T6 gives Eu=1, La_n=0, Su=0.
- SUB: Opcode=0010 → Su=1 and Eu=1 in T6 only; Su=0 in T4 and T5.
- Jumps:
  - Opcode=0011: T4 gives Ej=1, Ei_n=0, Cp=0.
  - Opcode=0100, Zf=0: Ej=0 through T6.
  - Opcode=0100, Zf=1: Ej=1 in T4.
- HLT and freeze: Opcode=1111 → HLT=1 after the T4 negedge; T stays 001000 for 10 further cycles with all controls inactive. Changing Opcode to 0000 does not restart the ring.
- Asynchronous reset: assert CLR mid-T5 of an ADD, and again while halted. T=000001 and HLT=0 without waiting for a clock edge, and Lb_n=1 immediately.

Source files
------------

// File: rtl/controlador_sequenciador.sv
`timescale 1ns/1ps
// controlador_sequenciador: SAP-1 six-state ring counter and control-word decoder.
// The ring steps on the falling edge, so the control word is settled for the datapath's rising edge.
module controlador_sequenciador (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [3:0] Opcode,
  input  logic       Zf,
  output logic       Cp,
  output logic       Ep,
  output logic       Ej,
  output logic       Lm_n,
  output logic       CE_n,
  output logic       Li_n,
  output logic       Ei_n,
  output logic       La_n,
  output logic       Ea,
  output logic       Su,
  output logic       Eu,
  output logic       Lb_n,
  output logic       Lo_n,
  output logic [5:0] T,
  output logic       HLT
);
  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_JMP = 4'b0011;
  localparam logic [3:0] OP_JZ  = 4'b0100;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;
  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } state_t;
  state_t state_q, state_d;
  logic hlt_q, hlt_d;
  always_ff @(negedge CLK or posedge CLR)
    if (CLR) begin
      state_q <= T1;
      hlt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hlt_q   <= hlt_d;
    end
  always_comb begin
    state_d = T1;
    hlt_d   = hlt_q;
    Cp = 1'b0; Ep = 1'b0; Ej = 1'b0; Ea = 1'b0; Su = 1'b0; Eu = 1'b0;
    Lm_n = 1'b1; CE_n = 1'b1; Li_n = 1'b1; Ei_n = 1'b1; La_n = 1'b1; Lb_n = 1'b1; Lo_n = 1'b1;
    if (hlt_q) state_d = state_q;
    else
      case (state_q)
        T1: begin
          state_d = T2;
          Ep = 1'b1; Lm_n = 1'b0;
        end
        T2: begin
          state_d = T3;
          Cp = 1'b1;
        end
        T3: begin
          state_d = T4;
          CE_n = 1'b0; Li_n = 1'b0;
        end
        T4: begin
          state_d = (Opcode == OP_HLT) ? T4 : T5;
          hlt_d   = (Opcode == OP_HLT);
          Ei_n = (Opcode == OP_LDA || Opcode == OP_ADD || Opcode == OP_SUB || Opcode == OP_JMP ||
                  (Opcode == OP_JZ && Zf)) ? 1'b0 : 1'b1;
          Lm_n = (Opcode == OP_LDA || Opcode == OP_ADD || Opcode == OP_SUB) ? 1'b0 : 1'b1;
          Ej   = (Opcode == OP_JMP || (Opcode == OP_JZ && Zf));
          Ea   = (Opcode == OP_OUT);
          Lo_n = (Opcode == OP_OUT) ? 1'b0 : 1'b1;
        end
        T5: begin
          state_d = T6;
          CE_n = (Opcode == OP_LDA || Opcode == OP_ADD || Opcode == OP_SUB) ? 1'b0 : 1'b1;
          La_n = (Opcode == OP_LDA) ? 1'b0 : 1'b1;
          Lb_n = (Opcode == OP_ADD || Opcode == OP_SUB) ? 1'b0 : 1'b1;
        end
        T6: begin
          state_d = T1;
          Eu   = (Opcode == OP_ADD || Opcode == OP_SUB);
          La_n = (Opcode == OP_ADD || Opcode == OP_SUB) ? 1'b0 : 1'b1;
          Su   = (Opcode == OP_SUB);
        end
        default: state_d = T1;
      endcase
  end
  assign T   = state_q;
  assign HLT = hlt_q;
endmodule

// File: tb/tb_controlador_sequenciador.sv
`timescale 1ns/1ps
// tb_controlador_sequenciador: directed instruction sequences checked against a step-count model of the SAP-1 controller.
module tb_controlador_sequenciador;
  logic CLK = 1'b0, CLR = 1'b0, Zf = 1'b0;
  logic [3:0] Opcode = 4'b0000;
  logic Cp, Ep, Ej, Lm_n, CE_n, Li_n, Ei_n, La_n, Ea, Su, Eu, Lb_n, Lo_n, HLT;
  logic [5:0] T;
  int checks = 0, errors = 0;
  bit chk_en = 1'b0;
  int step = 1;
  bit halted = 1'b0;
  localparam int CP = 12, EP = 11, EJ = 10, LM = 9, CE = 8, LI = 7, EI = 6, LA = 5, EA = 4, SU = 3, EU = 2, LB = 1, LO = 0;
  localparam logic [12:0] LOW_MASK = 13'h3E3;
  controlador_sequenciador dut (
    .CLK(CLK), .CLR(CLR), .Opcode(Opcode), .Zf(Zf),
    .Cp(Cp), .Ep(Ep), .Ej(Ej), .Lm_n(Lm_n), .CE_n(CE_n), .Li_n(Li_n), .Ei_n(Ei_n),
    .La_n(La_n), .Ea(Ea), .Su(Su), .Eu(Eu), .Lb_n(Lb_n), .Lo_n(Lo_n), .T(T), .HLT(HLT)
  );
  always #5 CLK = ~CLK;
  function automatic logic [12:0] asserted();
    return {Cp, Ep, Ej, Lm_n, CE_n, Li_n, Ei_n, La_n, Ea, Su, Eu, Lb_n, Lo_n} ^ LOW_MASK;
  endfunction
  function automatic logic [12:0] expect_mask(int s, bit h, logic [3:0] op, logic z);
    logic [12:0] m = '0;
    if (h) return m;
    case (s)
      1: begin m[EP] = 1; m[LM] = 1; end
      2: m[CP] = 1;
      3: begin m[CE] = 1; m[LI] = 1; end
      4: begin
        if (op <= 4'd2) begin m[EI] = 1; m[LM] = 1; end
        if (op == 4'd3 || (op == 4'd4 && z)) begin m[EI] = 1; m[EJ] = 1; end
        if (op == 4'd14) begin m[EA] = 1; m[LO] = 1; end
      end
      5: begin
        if (op <= 4'd2) m[CE] = 1;
        if (op == 4'd0) m[LA] = 1;
        if (op == 4'd1 || op == 4'd2) m[LB] = 1;
      end
      6: if (op == 4'd1 || op == 4'd2) begin m[EU] = 1; m[LA] = 1; m[SU] = (op == 4'd2); end
      default: ;
    endcase
    return m;
  endfunction
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge CLK or posedge CLR)
    if (CLR) begin
      step <= 1;
      halted <= 1'b0;
    end else if (!halted) begin
      if (step == 4 && Opcode == 4'd15) halted <= 1'b1;
      else step <= step % 6 + 1;
    end
  always @(posedge CLK)
    if (chk_en) begin
      check("model_T", T, 32'(6'b1 << (step - 1)));
      check("model_HLT", HLT, halted);
      check("model_word", asserted(), expect_mask(step, halted, Opcode, Zf));
      check("onehot_T", $onehot(T), 1);
      check("cp_ej_excl", Cp & Ej, 0);
    end
  task automatic tick(int n = 1);
    repeat (n) begin
      @(negedge CLK);
      #1;
    end
  endtask
  initial begin
    #2 CLR = 1'b1;
    #1;
    check("rst_T", T, 6'b000001);
    check("rst_HLT", HLT, 0);
    check("rst_word", asserted(), 13'h0A00);
    chk_en = 1'b1;
    tick(2);
    check("rst_hold_T", T, 6'b000001);
    #2 CLR = 1'b0;
    tick();
    check("run_T2", T, 6'b000010);
    tick(4);
    check("run_T6", T, 6'b100000);
    tick();
    check("run_wrap", T, 6'b000001);
    tick(3);
    check("lda_t4", asserted(), 13'h0240);
    tick();
    check("lda_t5", asserted(), 13'h0120);
    tick();
    check("lda_t6", asserted(), 0);
    tick();
    Opcode = 4'd1;
    tick(4);
    check("add_t5_lb", Lb_n, 0);
    tick();
    check("add_t6", asserted(), 13'h0024);
    tick();
    Opcode = 4'd2;
    tick(3);
    check("sub_t4_su", Su, 0);
    tick();
    check("sub_t5_su", Su, 0);
    tick();
    check("sub_t6", asserted(), 13'h002C);
    tick();
    Opcode = 4'd3;
    tick(3);
    check("jmp_t4_ej", Ej, 1);
    check("jmp_t4_ei", Ei_n, 0);
    check("jmp_t4_cp", Cp, 0);
    tick(3);
    Opcode = 4'd4;
    tick(3);
    check("jz0_t4_ej", Ej, 0);
    tick(3);
    Zf = 1'b1;
    tick(3);
    check("jz1_t4_ej", Ej, 1);
    tick(3);
    Zf = 1'b0;
    Opcode = 4'd14;
    tick(3);
    check("out_t4", asserted(), 13'h0011);
    tick(3);
    Opcode = 4'd5;
    tick(6);
    Opcode = 4'd1;
    tick(4);
    check("clr_pre_lb", Lb_n, 0);
    #2 CLR = 1'b1;
    #1;
    check("clr_mid_T", T, 6'b000001);
    check("clr_mid_lb", Lb_n, 1);
    check("clr_mid_ep", Ep, 1);
    tick();
    #2 CLR = 1'b0;
    Opcode = 4'd15;
    tick(3);
    check("hlt_t4_word", asserted(), 0);
    check("hlt_pre", HLT, 0);
    tick();
    check("hlt_set", HLT, 1);
    check("hlt_T", T, 6'b001000);
    Opcode = 4'd0;
    tick(10);
    check("hlt_frozen_T", T, 6'b001000);
    check("hlt_frozen_word", asserted(), 0);
    #2 CLR = 1'b1;
    #1;
    check("clr_hlt_T", T, 6'b000001);
    check("clr_hlt_HLT", HLT, 0);
    tick();
    #2 CLR = 1'b0;
    tick();
    check("after_clr_T2", T, 6'b000010);
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
